// File: rtl/fsk_frame_sched.sv
// Demand-driven frame scheduler for the FSK link: picks one word source per frame
// and sequences preamble, 16 data bits and guard with its own bit timing.
module fsk_frame_sched #(
    parameter int BIT_DIV   = 16,
    parameter int PRE_BITS  = 4,
    parameter int GUARD_CYC = 8
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       adc_req,
    input  logic       test_req,
    input  logic       abort,
    output logic       grant_adc,
    output logic       grant_test,
    output logic       sel_test,
    output logic       trans_enable,
    output logic       test_enable,
    output logic       dec_enable,
    output logic       bit_strobe,
    output logic [3:0] bit_index,
    output logic       busy,
    output logic       frame_done,
    output logic       abort_flag,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(BIT_DIV);
    localparam int PW = (PRE_BITS > 1) ? $clog2(PRE_BITS) : 1;
    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PRE   = 3'd2,
        S_DATA  = 3'd3,
        S_GUARD = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_bit_cnt;
    logic [PW-1:0]  r_pre_cnt;
    logic [GW-1:0]  r_guard_cnt;
    logic           r_last_test;

    logic w_any_req;
    logic w_pick_test;
    logic w_last_bit;
    logic w_abort_now;

    // Round-robin: on a tie the source that did not own the previous frame wins.
    assign w_any_req   = adc_req | test_req;
    assign w_pick_test = test_req & (~adc_req | ~r_last_test);
    assign w_last_bit  = (r_bit_cnt == CW'(BIT_DIV - 1));
    assign w_abort_now = abort & (r_state == S_LOAD || r_state == S_PRE ||
                                  r_state == S_DATA || r_state == S_GUARD);
    assign dbg_state   = r_state;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_pre_cnt    <= '0;
            r_guard_cnt  <= '0;
            r_last_test  <= 1'b1;
            grant_adc    <= 1'b0;
            grant_test   <= 1'b0;
            sel_test     <= 1'b0;
            trans_enable <= 1'b0;
            test_enable  <= 1'b0;
            dec_enable   <= 1'b0;
            bit_strobe   <= 1'b0;
            bit_index    <= 4'd0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            abort_flag   <= 1'b0;
        end else begin
            grant_adc  <= 1'b0;
            grant_test <= 1'b0;
            bit_strobe <= 1'b0;
            frame_done <= 1'b0;
            abort_flag <= 1'b0;
            if (w_abort_now) begin
                // last_grant is left alone so the aborted source loses the next tie
                r_state      <= S_IDLE;
                abort_flag   <= 1'b1;
                sel_test     <= 1'b0;
                trans_enable <= 1'b0;
                test_enable  <= 1'b0;
                dec_enable   <= 1'b0;
                bit_index    <= 4'd0;
                busy         <= 1'b0;
                r_bit_cnt    <= '0;
                r_pre_cnt    <= '0;
                r_guard_cnt  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_any_req) begin
                            r_state     <= S_LOAD;
                            busy        <= 1'b1;
                            grant_adc   <= ~w_pick_test;
                            grant_test  <= w_pick_test;
                            sel_test    <= w_pick_test;
                            r_last_test <= w_pick_test;
                            r_bit_cnt   <= '0;
                            r_pre_cnt   <= '0;
                            bit_index   <= 4'd0;
                        end
                    end
                    S_LOAD: begin
                        r_state      <= S_PRE;
                        trans_enable <= 1'b1;
                        test_enable  <= 1'b1;
                    end
                    S_PRE: begin
                        if (w_last_bit) begin
                            r_bit_cnt <= '0;
                            if (r_pre_cnt == PW'(PRE_BITS - 1)) begin
                                r_pre_cnt   <= '0;
                                r_state     <= S_DATA;
                                test_enable <= 1'b0;
                                dec_enable  <= 1'b1;
                            end else begin
                                r_pre_cnt <= r_pre_cnt + 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (w_last_bit) begin
                            r_bit_cnt <= '0;
                            if (bit_index == 4'd15) begin
                                bit_index    <= 4'd0;
                                r_state      <= S_GUARD;
                                trans_enable <= 1'b0;
                                r_guard_cnt  <= '0;
                            end else begin
                                bit_index <= bit_index + 4'd1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            // strobe is registered, so raise it one cycle ahead of the last count
                            bit_strobe <= (r_bit_cnt == CW'(BIT_DIV - 2));
                        end
                    end
                    S_GUARD: begin
                        if (r_guard_cnt == GW'(GUARD_CYC - 1)) begin
                            r_state     <= S_DONE;
                            frame_done  <= 1'b1;
                            dec_enable  <= 1'b0;
                            sel_test    <= 1'b0;
                            r_guard_cnt <= '0;
                        end else begin
                            r_guard_cnt <= r_guard_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fsk_frame_sched.sv
// Directed bench: unit 0 runs default timing, unit 1 the shortest legal timing.
module tb_fsk_frame_sched;

    logic       sysclk;
    logic       reset;
    logic       adc_req      [2];
    logic       test_req     [2];
    logic       abort        [2];
    logic       grant_adc    [2];
    logic       grant_test   [2];
    logic       sel_test     [2];
    logic       trans_enable [2];
    logic       test_enable  [2];
    logic       dec_enable   [2];
    logic       bit_strobe   [2];
    logic [3:0] bit_index    [2];
    logic       busy         [2];
    logic       frame_done   [2];
    logic       abort_flag   [2];
    logic [2:0] dbg_state    [2];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    fsk_frame_sched dut (
        .sysclk(sysclk), .reset(reset),
        .adc_req(adc_req[0]), .test_req(test_req[0]), .abort(abort[0]),
        .grant_adc(grant_adc[0]), .grant_test(grant_test[0]), .sel_test(sel_test[0]),
        .trans_enable(trans_enable[0]), .test_enable(test_enable[0]),
        .dec_enable(dec_enable[0]), .bit_strobe(bit_strobe[0]), .bit_index(bit_index[0]),
        .busy(busy[0]), .frame_done(frame_done[0]), .abort_flag(abort_flag[0]),
        .dbg_state(dbg_state[0])
    );

    fsk_frame_sched #(.BIT_DIV(2), .PRE_BITS(1), .GUARD_CYC(1)) dut_s (
        .sysclk(sysclk), .reset(reset),
        .adc_req(adc_req[1]), .test_req(test_req[1]), .abort(abort[1]),
        .grant_adc(grant_adc[1]), .grant_test(grant_test[1]), .sel_test(sel_test[1]),
        .trans_enable(trans_enable[1]), .test_enable(test_enable[1]),
        .dec_enable(dec_enable[1]), .bit_strobe(bit_strobe[1]), .bit_index(bit_index[1]),
        .busy(busy[1]), .frame_done(frame_done[1]), .abort_flag(abort_flag[1]),
        .dbg_state(dbg_state[1])
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] outs(input int u);
        return {grant_adc[u], grant_test[u], sel_test[u], trans_enable[u], test_enable[u],
                dec_enable[u], bit_strobe[u], bit_index[u], busy[u], frame_done[u],
                abort_flag[u]};
    endfunction

    // Called in the LOAD cycle; follows the frame to its DONE cycle.
    task automatic run_frame(input int u, input int bd, input int pre, input int grd,
                             input logic exp_sel, input int pulse_off, input int hold_off);
        int n_tr, n_te, n_de, n_st, bad_te, bad_sel, n_gr, done_off;
        n_tr = 0; n_te = 0; n_de = 0; n_st = 0; bad_te = 0; bad_sel = 0; n_gr = 0;
        done_off = -1;
        chk("load_grant_adc", grant_adc[u], !exp_sel);
        chk("load_grant_test", grant_test[u], exp_sel);
        chk("load_sel_test", sel_test[u], exp_sel);
        chk("load_busy", busy[u], 1);
        for (int off = 1; off <= 2000; off++) begin
            tick();
            if (off == pulse_off) adc_req[u] = 1'b1;
            if (off == pulse_off + 1) adc_req[u] = 1'b0;
            if (off == hold_off) test_req[u] = 1'b1;
            n_tr += int'(trans_enable[u]);
            n_te += int'(test_enable[u]);
            n_de += int'(dec_enable[u]);
            if (test_enable[u] !== ((off <= pre * bd) ? 1'b1 : 1'b0)) bad_te++;
            if (grant_adc[u] || grant_test[u]) n_gr++;
            if (bit_strobe[u]) begin
                chk("strobe_index", bit_index[u], n_st[3:0]);
                chk("strobe_offset", off, 1 + pre * bd + bd * (n_st + 1) - 1);
                n_st++;
            end
            if (frame_done[u]) begin
                done_off = off;
                break;
            end
            if (sel_test[u] !== exp_sel) bad_sel++;
        end
        chk("done_offset", done_off, 1 + (pre + 16) * bd + grd);
        chk("trans_cycles", n_tr, (pre + 16) * bd);
        chk("test_cycles", n_te, pre * bd);
        chk("dec_cycles", n_de, 16 * bd + grd);
        chk("strobe_count", n_st, 16);
        chk("test_en_window", bad_te, 0);
        chk("sel_test_hold", bad_sel, 0);
        chk("grants_in_frame", n_gr, 0);
        chk("done_sel_clear", sel_test[u], 0);
        chk("done_busy", busy[u], 1);
    endtask

    initial begin
        int n_st, n_act;
        reset = 1'b0;
        for (int u = 0; u < 2; u++) begin
            adc_req[u] = 1'b0; test_req[u] = 1'b0; abort[u] = 1'b0;
        end
        tick(); tick();
        chk("reset_outs_u0", outs(0), 14'd0);
        chk("reset_outs_u1", outs(1), 14'd0);
        reset = 1'b1;
        tick();
        chk("idle_no_req", {busy[0], dbg_state[0]}, 4'd0);

        // Single ADC request, default timing
        adc_req[0] = 1'b1;
        tick();
        adc_req[0] = 1'b0;
        run_frame(0, 16, 4, 8, 1'b0, -1, -1);
        tick();
        chk("idle_after_frame", busy[0], 0);

        // Both requests held: alternation with one IDLE cycle between frames
        adc_req[0] = 1'b1; test_req[0] = 1'b1;
        tick();
        run_frame(0, 16, 4, 8, 1'b1, -1, -1);
        tick();
        chk("gap1_idle", {busy[0], grant_adc[0], grant_test[0], dbg_state[0]}, 6'd0);
        tick();
        run_frame(0, 16, 4, 8, 1'b0, -1, -1);
        tick();
        chk("gap2_idle", {busy[0], grant_adc[0], grant_test[0], dbg_state[0]}, 6'd0);
        tick();
        run_frame(0, 16, 4, 8, 1'b1, -1, -1);
        adc_req[0] = 1'b0; test_req[0] = 1'b0;
        tick();

        // Abort on the 5th data strobe; requests stay high
        adc_req[0] = 1'b1; test_req[0] = 1'b1;
        tick();
        chk("abort_frame_grant_adc", grant_adc[0], 1);
        n_st = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (bit_strobe[0]) n_st++;
            if (n_st == 5) break;
        end
        chk("abort_reached_strobe5", n_st, 5);
        chk("abort_strobe5_index", bit_index[0], 4);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("abort_cycle_outs", outs(0), 14'd1);
        chk("abort_state_idle", dbg_state[0], 0);
        tick();
        chk("after_abort_grant_test", grant_test[0], 1);
        chk("after_abort_no_flag", abort_flag[0], 0);
        adc_req[0] = 1'b0; test_req[0] = 1'b0;
        run_frame(0, 16, 4, 8, 1'b1, -1, -1);
        tick();
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("abort_in_idle_ignored", {abort_flag[0], busy[0]}, 2'd0);

        // Asynchronous reset mid-DATA
        adc_req[0] = 1'b1;
        tick();
        adc_req[0] = 1'b0;
        repeat (150) tick();
        chk("mid_data_busy", {busy[0], dbg_state[0]}, {1'b1, 3'd3});
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outs", outs(0), 14'd0);
        chk("async_reset_state", dbg_state[0], 0);
        @(posedge sysclk);
        #3 reset = 1'b1;
        tick();
        test_req[0] = 1'b1;
        tick();
        test_req[0] = 1'b0;
        run_frame(0, 16, 4, 8, 1'b1, -1, -1);
        adc_req[0] = 1'b1; test_req[0] = 1'b1;
        tick();
        chk("tie_after_reset_idle", busy[0], 0);
        tick();
        adc_req[0] = 1'b0; test_req[0] = 1'b0;
        run_frame(0, 16, 4, 8, 1'b0, -1, -1);
        tick();

        // Minimum timing unit
        adc_req[1] = 1'b1;
        tick();
        adc_req[1] = 1'b0;
        run_frame(1, 2, 1, 1, 1'b0, -1, -1);
        tick();
        chk("small_idle", busy[1], 0);

        // Request raised in GUARD waits for IDLE; a one-cycle pulse in DATA is ignored
        adc_req[0] = 1'b1;
        tick();
        adc_req[0] = 1'b0;
        run_frame(0, 16, 4, 8, 1'b0, -1, 325);
        tick();
        chk("guard_req_idle", {busy[0], grant_test[0]}, 2'd0);
        tick();
        test_req[0] = 1'b0;
        run_frame(0, 16, 4, 8, 1'b1, 100, -1);
        n_act = 0;
        repeat (8) begin
            tick();
            n_act += int'(busy[0] | grant_adc[0] | grant_test[0]);
        end
        chk("pulse_no_second_frame", n_act, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
